// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer.
// Capture FSM encoding, error-bit positions and entry layout.
package uart_pkg;

   localparam int DATA_W  = 8;
   localparam int ENTRY_W = 11;

   localparam int ERR_PERR = 0;
   localparam int ERR_FERR = 1;
   localparam int ERR_OVF  = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACK      = 2'd1,
      WAIT_LOW = 2'd2
   } cap_state_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array FIFO with first-word-fall-through read port.
// Holds pointers, occupancy and full/empty for the receive buffer.
module uart_rx_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               rd_en,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               empty,
   output logic               full,
   output logic [AW:0]        count
);

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               wr_do;
   logic               rd_do;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_do = wr_en & (~full | rd_en);
   assign rd_do = rd_en & ~empty;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));

   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_do) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_do) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_do && !rd_do) begin
            count <= count + (AW+1)'(1);
         end else if (!wr_do && rd_do) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures bytes and status from the engine,
// acknowledges with READS, and exposes a FWFT read port.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RXRDY,
   input  logic [DATA_W-1:0] UART_RDATA,
   input  logic              PERR,
   input  logic              FERR,
   input  logic              OVF,
   output logic              READS,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic [2:0]        rd_err,
   output logic              empty,
   output logic              full,
   output logic [AW:0]       count,
   output logic              drop,
   input  logic              clr_drop
);

   cap_state_t         state_q;
   cap_state_t         state_d;
   logic               reads_d;
   logic               wr_req;
   logic               drop_set;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;

   always_comb begin
      wr_entry = '0;
      wr_entry[DATA_W-1:0]        = UART_RDATA;
      wr_entry[DATA_W + ERR_PERR] = PERR;
      wr_entry[DATA_W + ERR_FERR] = FERR;
      wr_entry[DATA_W + ERR_OVF]  = OVF;
   end

   always_comb begin
      state_d = state_q;
      reads_d = 1'b0;
      wr_req  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (RXRDY) begin
               wr_req  = 1'b1;
               reads_d = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            // Keep clearing while a slow DONE keeps re-setting the flag.
            reads_d = RXRDY;
            if (!RXRDY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign drop_set = wr_req & full & ~rd_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         READS   <= 1'b0;
         drop    <= 1'b0;
      end else begin
         state_q <= state_d;
         READS   <= reads_d;
         if (drop_set) begin
            drop <= 1'b1;
         end else if (clr_drop) begin
            drop <= 1'b0;
         end
      end
   end

   uart_rx_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_req),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_data (head),
      .empty   (empty),
      .full    (full),
      .count   (count)
   );

   assign rd_data = head[DATA_W-1:0];
   assign rd_err  = head[ENTRY_W-1:DATA_W];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected entries,
// a negedge monitor compares every pop against the queue.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       RXRDY = 1'b0;
   logic [7:0] UART_RDATA = '0;
   logic       PERR = 1'b0;
   logic       FERR = 1'b0;
   logic       OVF = 1'b0;
   logic       READS;
   logic       rd_en = 1'b0;
   logic [7:0] rd_data;
   logic [2:0] rd_err;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       drop;
   logic       clr_drop = 1'b0;

   int checks = 0;
   int passes = 0;
   int reads_hi;
   logic [10:0] exp_q[$];
   logic [10:0] mon_e;

   uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .RXRDY      (RXRDY),
      .UART_RDATA (UART_RDATA),
      .PERR       (PERR),
      .FERR       (FERR),
      .OVF        (OVF),
      .READS      (READS),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .drop       (drop),
      .clr_drop   (clr_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One engine handshake: flag for one edge, then dropped after READS.
   task automatic send_byte(input logic [7:0] b, input logic [2:0] e,
                            input bit store, input bit clr);
      RXRDY = 1'b1;
      UART_RDATA = b;
      {OVF, FERR, PERR} = e;
      clr_drop = clr;
      if (store) exp_q.push_back({e, b});
      step();
      chk("reads_ack", READS, 1);
      RXRDY = 1'b0;
      clr_drop = 1'b0;
      {OVF, FERR, PERR} = 3'b000;
      step();
      step();
   endtask

   task automatic drain(input int n);
      rd_en = 1'b1;
      for (int i = 0; i < n; i++) step();
      rd_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset && rd_en && !empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL pop_extra: got %0h expected none", rd_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pop_data", rd_data, mon_e[7:0]);
            chk("pop_err", rd_err, mon_e[10:8]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step();
      step();
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_reads", READS, 0);
      chk("rst_drop", drop, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_err", rd_err, 0);
      reset = 1'b1;
      step();

      // single byte
      send_byte(8'hA5, 3'b000, 1, 0);
      chk("one_count", count, 1);
      chk("one_empty", empty, 0);
      chk("one_data", rd_data, 8'hA5);
      chk("one_err", rd_err, 0);
      drain(1);
      chk("one_drained", empty, 1);
      chk("empty_data", rd_data, 0);

      // read while empty is ignored
      drain(1);
      chk("rd_empty_cnt", count, 0);
      chk("rd_empty_emp", empty, 1);

      // error bits carried
      send_byte(8'h3C, 3'b011, 1, 0);
      chk("err_err", rd_err, 3'b011);
      chk("err_data", rd_data, 8'h3C);
      drain(1);

      // fill, overflow, drop
      for (int i = 0; i < 16; i++) send_byte(8'(i), 3'b000, 1, 0);
      chk("fill_full", full, 1);
      chk("fill_count", count, 16);
      chk("fill_drop0", drop, 0);
      send_byte(8'hFF, 3'b000, 0, 0);
      chk("ovf_drop", drop, 1);
      chk("ovf_count", count, 16);
      send_byte(8'hFE, 3'b100, 0, 1);
      chk("set_wins", drop, 1);
      clr_drop = 1'b1;
      step();
      clr_drop = 1'b0;
      chk("clr_drop", drop, 0);
      drain(16);
      chk("ovf_drained", empty, 1);

      // simultaneous write and read at full
      for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i), 3'b001, 1, 0);
      chk("sim_full", full, 1);
      RXRDY = 1'b1;
      UART_RDATA = 8'h77;
      exp_q.push_back({3'b000, 8'h77});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("sim_reads", READS, 1);
      RXRDY = 1'b0;
      step();
      step();
      chk("sim_count", count, 16);
      chk("sim_drop", drop, 0);
      drain(16);
      chk("sim_drained", empty, 1);

      // flag held high after the acknowledge
      RXRDY = 1'b1;
      UART_RDATA = 8'h5A;
      exp_q.push_back({3'b000, 8'h5A});
      reads_hi = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (READS) reads_hi++;
      end
      chk("hold_repulse", READS, 1);
      RXRDY = 1'b0;
      step();
      if (READS) reads_hi++;
      step();
      chk("hold_pulses", 32'(reads_hi >= 3), 1);
      chk("hold_one", count, 1);
      drain(1);

      // reset mid-handshake with entries buffered
      for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i), 3'b010, 1, 0);
      chk("pre_rst_cnt", count, 5);
      RXRDY = 1'b1;
      UART_RDATA = 8'h11;
      step();
      chk("mid_reads", READS, 1);
      reset = 1'b0;
      #1;
      exp_q.delete();
      chk("mrst_count", count, 0);
      chk("mrst_empty", empty, 1);
      chk("mrst_reads", READS, 0);
      chk("mrst_data", rd_data, 0);
      step();
      reset = 1'b1;
      exp_q.push_back({3'b000, 8'h11});
      step();
      chk("post_reads", READS, 1);
      chk("post_count", count, 1);
      RXRDY = 1'b0;
      step();
      step();
      drain(1);
      chk("final_empty", empty, 1);
      chk("queue_done", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer sitting directly downstream of the UART receive engine. Watches the engine's RXRDY flag, captures the received byte plus its PERR/FERR/OVF status into a FIFO, and pulses READS back to the engine to clear its flags. The processor side then drains bytes at its own pace through a first-word-fall-through read port, decoupling bus read latency from line bit-time.

## Interface
- DEPTH, 16, number of entries; power of two, at least 2
- AW, 4, pointer width, log2(DEPTH)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- RXRDY  in  1  receive engine data-ready flag (level)
- UART_RDATA  in  8  received byte from receive engine
- PERR, FERR, OVF  in  1 each  receive engine error flags, valid while RXRDY=1
- READS  out  1  flag-clear pulse to receive engine
- rd_en  in  1  processor read/pop strobe, one pop per cycle high
- rd_data  out  8  head-entry byte (FWFT)
- rd_err  out  3  head-entry status {OVF,FERR,PERR}
- empty  out  1  FIFO holds no entries
- full  out  1  FIFO holds DEPTH entries
- count  out  AW+1  current occupancy, 0..DEPTH
- drop  out  1  sticky: a byte was lost because FIFO was full
- clr_drop  in  1  clears drop

## Operation
- Entry format: 11 bits, {OVF,FERR,PERR,byte}.
- Capture FSM, three states:
  - IDLE: RXRDY=1 -> write entry (or drop, see below) on this edge, go ACK.
  - ACK: READS=1 this cycle; go WAIT_LOW.
  - WAIT_LOW: READS=RXRDY, re-asserted every cycle RXRDY is still high to absorb flag re-set by a multi-cycle DONE. No further captures. RXRDY=0 -> IDLE.
- Write while full: byte is discarded, drop set, READS still issued. No stall toward the engine.
- Simultaneous write and rd_en while full: the read frees the slot, the write is accepted, count is unchanged, drop is not set.
- rd_en while empty: ignored; pointers, count and outputs unchanged.
- rd_data/rd_err: combinational from the head entry when !empty; all-zero when empty.
- Pointers are AW bits and wrap DEPTH-1 -> 0. count is updated +1 / -1 / 0 per edge.
- clr_drop and a new drop on the same edge: drop stays 1, set wins.

## Timing
- Reset values: READS=0, empty=1, full=0, count=0, drop=0, rd_data=0, rd_err=0, FSM=IDLE, pointers=0.
- Capture latency: RXRDY high sampled at edge N -> entry written at N. At N+, count increments, empty falls, and READS=1 for cycle N..N+1.
- Read: rd_en high at edge M -> head advances at M. The next entry is visible in the same cycle after M.
- READS is a registered output, one cycle wide per assertion; back-to-back only in WAIT_LOW.
- reset asserted mid-frame or mid-handshake: FIFO contents are discarded and the FSM returns to IDLE. A still-high RXRDY after reset release is captured as a new byte.

## Structure
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE/ACK/WAIT_LOW)
  - error-bit index constants (ERR_PERR=0, ERR_FERR=1, ERR_OVF=2)
  - entry width constant (11)
- Sub-module uart_rx_fifo_mem: register-array storage, write/read pointers, count, full/empty. The top holds the capture FSM, READS and drop.

## Test plan
- Single byte: RXRDY rises with 8'hA5, errors 0 -> one READS pulse. Then count=1, rd_data=A5, rd_err=0. rd_en -> empty=1.
- Errors carried: byte 8'h3C with FERR=1, PERR=1 -> rd_err=3'b011, rd_data=3C.
- Fill and overflow: 16 bytes 00..0F, then 8'hFF -> full=1, drop=1, count=16, READS still pulsed. Drain returns 00..0F in order, no FF.
- Simultaneous write and read at full -> count stays 16, drop stays 0. Final drain ends with the new byte.
- RXRDY held high 3 cycles after the first READS -> READS re-pulses each cycle, exactly one entry is written.
- reset pulsed low with 5 entries buffered -> count=0, empty=1, READS=0 immediately. The next byte is captured normally.
